keypad_scan_debounce: RTL
=========================

Name: keypad_scan_debounce

Overview:
- Drives the 4x4 keypad columns, samples the rows, and debounces presses and releases.
- Emits exactly one key event per physical press: a one-cycle valid strobe plus a 4-bit hex key code.
- Sits directly upstream of number_bank, which consumes key_valid/key_code; runs on the HSOSC clock at top level.

Parameters:
- SCAN_DWELL, 16: clock cycles each column is driven before advancing.
- DEBOUNCE_CYCLES, 150000: consecutive stable cycles required to accept a press or a release.
- CNT_W, 24: width of the dwell and debounce counters; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock (HSOSC).
- reset  input  1  asynchronous, active-low reset.
- R  input  4  raw keypad rows, active-high (pull-down), asynchronous to clk.
- C  output  4  keypad column drive, one-hot active-high.
- key_valid  output  1  one-cycle strobe, new debounced key accepted.
- key_code  output  4  hex value of the accepted key; held until the next accept.
- key_held  output  1  high from accept until release is debounced.

Behaviour:
- Reset (reset=0, async):
  - C=4'b0001, key_valid=0, key_code=0, key_held=0.
  - State=SCAN; all counters 0; synchronizer flops 0.
- Row input: 2-flop synchronizer on R produces rs. All decisions use rs only.
- Row qualification: a row sample is qualified only if it is exactly one-hot. Zero or multi-hot samples are never accepted.
- SCAN:
  - The current column is driven for SCAN_DWELL cycles.
  - On the last dwell cycle, if rs is qualified: latch col_idx and row_idx, freeze C, clear the debounce counter, go DEBOUNCE.
  - Otherwise C rotates 0001→0010→0100→1000→0001.
- DEBOUNCE:
  - Each cycle rs equals the latched one-hot row: increment the counter.
  - Any mismatch (zero, other row, multi-hot): abandon, go SCAN with C advanced to the next column, no output.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match: next cycle key_valid=1 for exactly one cycle, key_code=map(row_idx,col_idx), key_held=1, go HELD.
- HELD:
  - C stays frozen.
  - Other rows in the same column, and keys in other columns, are ignored and generate no events.
  - When rs==0: clear the counter, go RELEASE.
- RELEASE:
  - Counts consecutive rs==0 cycles.
  - Any nonzero rs: return to HELD and clear the counter. Bounce on release produces no second event.
  - At DEBOUNCE_CYCLES consecutive zeros: key_held=0, go SCAN starting at the column after col_idx with a fresh dwell.
- Key map, rows r0..r3 by columns c0..c3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- key_valid is never asserted in consecutive cycles. Minimum spacing between strobes is 2*DEBOUNCE_CYCLES.
- Reset mid-operation forces the reset values immediately. No partial event is emitted.
- Counters saturate rather than wrap. CNT_W is sized so no overflow occurs at the defaults.
- Total latency from the first stable synchronized row sample to key_valid:
  - remaining dwell cycles, plus
  - DEBOUNCE_CYCLES, plus
  - 1 cycle,
  - plus 2 cycles of synchronizer delay relative to raw R.

Test Plan:
- Bench uses SCAN_DWELL=4, DEBOUNCE_CYCLES=8.
- Reset/idle: reset=0 then 1, R=0 for 64 cycles -> C rotates 0001,0010,0100,1000 every 4 cycles; key_valid never 1; key_code=0; key_held=0.
- Clean press: R=4'b0001 held while C=4'b0010 and released after 40 cycles -> exactly one key_valid pulse, key_code=4'h2, 9 cycles after the freeze; key_held high until 8 zero cycles after release; scanning resumes at C=4'b0100.
- Bouncy press: R=0001 toggles every 3 cycles for 20 cycles while C=4'b1000, then held stable -> no strobe during bounce; single strobe with key_code=4'hA after 8 stable cycles.
- Bouncy release plus second key: during HELD on key 5 (r1,c1), release with 3 glitches of R=0010, then press r2 in the same column -> exactly one strobe total (4'h5) until 8 clean zero cycles elapse.
- Multi-key: R=4'b0011 while C=4'b0001 -> never leaves SCAN, no strobe; then R=4'b1000 at C=4'b0010 -> strobe with key_code=4'h0.
- Reset mid-debounce: assert reset at debounce count 5 -> outputs return to reset values within the same cycle; no strobe after reset deasserts while R=0.

Source files
------------

// File: rtl/keypad_scan_debounce_if.sv
// Key event bus between the keypad scanner and its consumer (number_bank).
//   key_valid : one-cycle strobe, a new debounced key was accepted
//   key_code  : hex code of the last accepted key, held until the next accept
//   key_held  : high from accept until the release has been debounced
// modport master : driven by keypad_scan_debounce
// modport slave  : observed by the consumer
interface keypad_scan_debounce_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (output key_valid, key_code, key_held);
    modport slave  (input  key_valid, key_code, key_held);
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner with press/release debounce.
// Drives one column at a time, samples the (synchronized) rows and emits a
// single key event per physical press on the key interface.
//   clk   : system clock (HSOSC)
//   reset : asynchronous, active-low reset
//   R     : raw keypad rows, active-high, asynchronous to clk
//   C     : one-hot active-high column drive
//   key   : key event bus (key_valid / key_code / key_held), master side
module keypad_scan_debounce #(
    parameter int unsigned SCAN_DWELL      = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 150000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             R,
    output logic [3:0]             C,
    keypad_scan_debounce_if.master key
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       sync1_q;
    logic [3:0]       rs_q;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_q, row_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic             valid_q, valid_d;
    logic [3:0]       code_q, code_d;
    logic             held_q, held_d;
    logic             rs_onehot;

    function automatic logic [1:0] row_enc(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Physical legend: rows r0..r3 top to bottom, columns c0..c3 left to right.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
        rs_onehot = (rs_q != 4'b0000) && ((rs_q & (rs_q - 4'd1)) == 4'b0000);

        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        row_d     = row_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        held_d    = held_q;

        case (state_q)
            SCAN: begin
                if (dwell_q >= DWELL_LAST) begin
                    dwell_d = '0;
                    if (rs_onehot) begin
                        row_d     = rs_q;
                        row_idx_d = row_enc(rs_q);
                        deb_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = sat_inc(dwell_q);
                end
            end
            DEBOUNCE: begin
                if (rs_q == row_q) begin
                    if (deb_q >= DEB_LAST) begin
                        valid_d = 1'b1;
                        code_d  = key_map(row_idx_q, col_idx_q);
                        held_d  = 1'b1;
                        deb_d   = '0;
                        state_d = HELD;
                    end else begin
                        deb_d = sat_inc(deb_q);
                    end
                end else begin
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    state_d   = SCAN;
                end
            end
            HELD: begin
                if (rs_q == 4'b0000) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rs_q != 4'b0000) begin
                    deb_d   = '0;
                    state_d = HELD;
                end else if (deb_q >= DEB_LAST) begin
                    held_d    = 1'b0;
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    state_d   = SCAN;
                end else begin
                    deb_d = sat_inc(deb_q);
                end
            end
            default: state_d = SCAN;
        endcase

        col_d = 4'b0001 << col_idx_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            sync1_q   <= '0;
            rs_q      <= '0;
            col_idx_q <= '0;
            col_q     <= 4'b0001;
            row_idx_q <= '0;
            row_q     <= '0;
            dwell_q   <= '0;
            deb_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            held_q    <= 1'b0;
        end else begin
            sync1_q   <= R;
            rs_q      <= sync1_q;
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            row_idx_q <= row_idx_d;
            row_q     <= row_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            held_q    <= held_d;
        end
    end

    assign C             = col_q;
    assign key.key_valid = valid_q;
    assign key.key_code  = code_q;
    assign key.key_held  = held_q;

endmodule
